// File: rtl/pe1_stage_sched_if.sv
// Bus between top-level control, RAM/twiddle ROM/PE1 and the butterfly stage scheduler.
// The scheduler itself connects through the slave modport. The controlling side connects through master.
interface pe1_stage_sched_if #(
    parameter int LOG_N = 8
);
    logic             start;
    logic             mode;
    logic             rd_en;
    logic [LOG_N-1:0] rd_addr_u;
    logic [LOG_N-1:0] rd_addr_v;
    logic [LOG_N-2:0] tw_addr;
    logic             pe_sel;
    logic             wr_en;
    logic [LOG_N-1:0] wr_addr_u;
    logic [LOG_N-1:0] wr_addr_v;
    logic [2:0]       stage;
    logic             busy;
    logic             done;

    modport master (
        output start, mode,
        input  rd_en, rd_addr_u, rd_addr_v, tw_addr, pe_sel,
        input  wr_en, wr_addr_u, wr_addr_v, stage, busy, done
    );

    modport slave (
        input  start, mode,
        output rd_en, rd_addr_u, rd_addr_v, tw_addr, pe_sel,
        output wr_en, wr_addr_u, wr_addr_v, stage, busy, done
    );
endinterface

// File: rtl/pe1_stage_sched.sv
// PE1 stage scheduler: walks every butterfly pair of every NTT/INTT stage.
// It issues one read pair plus a twiddle index per cycle.
// It replays the read addresses as in-place write addresses after the RAM+PE latency.
// It drains the PE pipeline between stages so no stage reads a word still being written.
module pe1_stage_sched #(
    parameter int N      = 256,
    parameter int LOG_N  = 8,
    parameter int STAGES = 7,
    parameter int RD_LAT = 1,
    parameter int PE_LAT = 6
) (
    input  logic                clk,
    input  logic                rst,
    pe1_stage_sched_if.slave    bus
);
    localparam int WB_LAT = RD_LAT + PE_LAT;
    localparam int HALF   = N / 2;
    localparam int DCW    = $clog2(WB_LAT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             mode_q;
    logic [2:0]       stage_q;
    logic [LOG_N-2:0] pair_cnt_q;
    logic [LOG_N-1:0] offset_q;
    logic [LOG_N-1:0] group_q;
    logic [LOG_N-1:0] base_q;      // group * 2 * len, advanced by addition
    logic [DCW-1:0]   drain_cnt_q;

    logic [LOG_N-1:0] len;
    logic [LOG_N-1:0] groups;
    logic [LOG_N-1:0] tw_full;
    logic             last_pair;
    logic             last_off;
    logic             drain_last;
    logic             last_stage;

    // Write-back delay line: read strobe and address pair, WB_LAT deep.
    logic [WB_LAT-1:0] sr_en_q;
    logic [LOG_N-1:0]  sr_u_q [WB_LAT];
    logic [LOG_N-1:0]  sr_v_q [WB_LAT];

    // Derive per-stage butterfly span, group count and loop-end flags.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        len    = '0;
        groups = LOG_N'(N >> (32'(stage_q) + 2));
        if (mode_q) len = LOG_N'(2) << stage_q;
        else        len = LOG_N'(N >> (32'(stage_q) + 1));
        last_pair  = (pair_cnt_q == (LOG_N-1)'(HALF - 1));
        last_off   = (offset_q == len - LOG_N'(1));
        drain_last = (drain_cnt_q == DCW'(WB_LAT - 1));
        last_stage = (stage_q == 3'(STAGES - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_pair) state_d = DRAIN;
            DRAIN:   if (drain_last) state_d = last_stage ? DONE : RUN;
            default: state_d = IDLE;
        endcase
    end

    // Output decode. Read-side buses are forced to zero outside RUN.
    always_comb begin
        tw_full = '0;
        if (mode_q) tw_full = (groups << 1) - LOG_N'(1) - group_q;
        else        tw_full = (LOG_N'(1) << stage_q) + group_q;

        bus.rd_en     = (state_q == RUN);
        bus.rd_addr_u = '0;
        bus.rd_addr_v = '0;
        bus.tw_addr   = '0;
        if (state_q == RUN) begin
            bus.rd_addr_u = base_q + offset_q;
            bus.rd_addr_v = base_q + offset_q + len;
            bus.tw_addr   = tw_full[LOG_N-2:0];
        end
        bus.pe_sel    = mode_q;
        bus.stage     = stage_q;
        bus.busy      = (state_q == RUN) || (state_q == DRAIN);
        bus.done      = (state_q == DONE);
        bus.wr_en     = sr_en_q[WB_LAT-1];
        bus.wr_addr_u = sr_u_q[WB_LAT-1];
        bus.wr_addr_v = sr_v_q[WB_LAT-1];
    end

    // Mode latch, stage index, nested group/offset counters and drain timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q      <= 1'b0;
            stage_q     <= '0;
            pair_cnt_q  <= '0;
            offset_q    <= '0;
            group_q     <= '0;
            base_q      <= '0;
            drain_cnt_q <= '0;
        end else begin
            if (state_q == IDLE && bus.start) mode_q <= bus.mode;

            if (state_q == DONE)
                stage_q <= '0;
            else if (state_q == DRAIN && drain_last && !last_stage)
                stage_q <= stage_q + 3'd1;

            if (state_q == RUN) begin
                pair_cnt_q <= pair_cnt_q + 1'b1;
                if (last_off) begin
                    offset_q <= '0;
                    group_q  <= group_q + LOG_N'(1);
                    base_q   <= base_q + (len << 1);
                end else begin
                    offset_q <= offset_q + LOG_N'(1);
                end
            end else begin
                pair_cnt_q <= '0;
                offset_q   <= '0;
                group_q    <= '0;
                base_q     <= '0;
            end

            if (state_q == DRAIN) drain_cnt_q <= drain_cnt_q + DCW'(1);
            else                  drain_cnt_q <= '0;
        end
    end

    // Delay line that turns each issued read into its in-place write WB_LAT cycles later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the delay-line storage is reset too, so a reset mid-transform can never leak a stale write.
            sr_en_q <= '0;
            for (int i = 0; i < WB_LAT; i++) begin
                sr_u_q[i] <= '0;
                sr_v_q[i] <= '0;
            end
        end else begin
            sr_en_q   <= {sr_en_q[WB_LAT-2:0], bus.rd_en};
            sr_u_q[0] <= bus.rd_addr_u;
            sr_v_q[0] <= bus.rd_addr_v;
            for (int i = 1; i < WB_LAT; i++) begin
                sr_u_q[i] <= sr_u_q[i-1];
                sr_v_q[i] <= sr_v_q[i-1];
            end
        end
    end
endmodule

// File: tb/tb_pe1_stage_sched.sv
// Self-checking bench for pe1_stage_sched.
// The reference model is the textbook in-place NTT loop nest with a running twiddle counter.
// The counter counts up from 1 for forward transforms and down from N/2-1 for inverse ones.
// Expected reads and writes are queued at start and checked by a monitor.
module tb_pe1_stage_sched;
    localparam int N        = 256;
    localparam int LOG_N    = 8;
    localparam int STAGES   = 7;
    localparam int WB_LAT   = 7;
    localparam int BUSY_CYC = STAGES * (N / 2 + WB_LAT);

    typedef struct {
        int t;
        int u;
        int v;
        int tw;
        int st;
        int sel;
    } rd_exp_t;

    typedef struct {
        int t;
        int u;
        int v;
    } wr_exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   start_cyc;
    bit   active;
    int   n_tests;
    int   n_fail;
    int   mon_t;
    rd_exp_t rd_q[$];
    wr_exp_t wr_q[$];
    rd_exp_t rexp;
    wr_exp_t wexp;

    pe1_stage_sched_if #(.LOG_N(LOG_N)) bus ();

    pe1_stage_sched #(
        .N(N), .LOG_N(LOG_N), .STAGES(STAGES), .RD_LAT(1), .PE_LAT(6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference schedule: classic in-place loops, timing from stage length plus drain.
    task automatic push_transform(input bit m);
        int k;
        int len;
        int i;
        int t;
        k = m ? (N / 2 - 1) : 1;
        for (int s = 0; s < STAGES; s++) begin
            len = m ? (2 << s) : (N >> (s + 1));
            i   = 0;
            for (int st = 0; st < N; st += 2 * len) begin
                for (int j = st; j < st + len; j++) begin
                    t = 1 + s * (N / 2 + WB_LAT) + i;
                    rd_q.push_back('{t: t, u: j, v: j + len, tw: k, st: s, sel: int'(m)});
                    wr_q.push_back('{t: t + WB_LAT, u: j, v: j + len});
                    i++;
                end
                k = m ? k - 1 : k + 1;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"},  bus.rd_en, 0);
        check({tag, "_rd_u"},   bus.rd_addr_u, 0);
        check({tag, "_rd_v"},   bus.rd_addr_v, 0);
        check({tag, "_tw"},     bus.tw_addr, 0);
        check({tag, "_pe_sel"}, bus.pe_sel, 0);
        check({tag, "_wr_en"},  bus.wr_en, 0);
        check({tag, "_wr_u"},   bus.wr_addr_u, 0);
        check({tag, "_wr_v"},   bus.wr_addr_v, 0);
        check({tag, "_stage"},  bus.stage, 0);
        check({tag, "_busy"},   bus.busy, 0);
        check({tag, "_done"},   bus.done, 0);
    endtask

    task automatic apply_reset();
        active = 1'b0;
        rd_q.delete();
        wr_q.delete();
        rst = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(posedge clk);
        #1;
        check("rst_hold_wr_en", bus.wr_en, 0);
        rst = 1'b1;
    endtask

    // Runs one transform from a posedge+1 time point. It ends at posedge+1 of the IDLE cycle after done.
    task automatic run(input bit m, input int busy_at, input int rst_at);
        bit got;
        push_transform(m);
        start_cyc = cyc;
        active    = 1'b1;
        bus.start = 1'b1;
        bus.mode  = m;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mode  = 1'($urandom);
        got = 1'b0;
        for (int c = 0; c < 2 * BUSY_CYC && !got; c++) begin
            bus.start = (busy_at > 0 && c == busy_at);
            if (bus.start) bus.mode = ~m;
            if (rst_at > 0 && c == rst_at) begin
                bus.start = 1'b0;
                apply_reset();
                return;
            end
            if (bus.done) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        bus.start = 1'b0;
        check("done_seen", got, 1);
        @(posedge clk);
        #1;
        active = 1'b0;
        check("rd_q_empty", rd_q.size(), 0);
        check("wr_q_empty", wr_q.size(), 0);
        check("idle_busy", bus.busy, 0);
        check("idle_done", bus.done, 0);
        check("idle_stage", bus.stage, 0);
        if (!got) begin
            rd_q.delete();
            wr_q.delete();
            rst = 1'b0;
            #1;
            rst = 1'b1;
        end
    endtask

    // Monitor: cycle-level busy/done timing plus scoreboard pops on every read and write strobe.
    always @(negedge clk) begin
        if (rst) begin
            mon_t = cyc - start_cyc;
            if (active) begin
                check("busy", bus.busy, (mon_t >= 1 && mon_t <= BUSY_CYC));
                check("done", bus.done, (mon_t == BUSY_CYC + 1));
            end else begin
                check("quiet_rd_en", bus.rd_en, 0);
                check("quiet_wr_en", bus.wr_en, 0);
                check("quiet_busy",  bus.busy, 0);
                check("quiet_done",  bus.done, 0);
            end
            if (bus.rd_en) begin
                if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
                else begin
                    rexp = rd_q.pop_front();
                    check("rd_time",  mon_t, rexp.t);
                    check("rd_u",     bus.rd_addr_u, rexp.u);
                    check("rd_v",     bus.rd_addr_v, rexp.v);
                    check("tw_addr",  bus.tw_addr, rexp.tw);
                    check("rd_stage", bus.stage, rexp.st);
                    check("pe_sel",   bus.pe_sel, rexp.sel);
                end
            end
            if (bus.wr_en) begin
                if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
                else begin
                    wexp = wr_q.pop_front();
                    check("wr_time", mon_t, wexp.t);
                    check("wr_u",    bus.wr_addr_u, wexp.u);
                    check("wr_v",    bus.wr_addr_v, wexp.v);
                end
            end
        end
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        cyc       = 0;
        start_cyc = 0;
        active    = 1'b0;
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        rst       = 1'b0;
        #1;
        check_all_zero("rst_init");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Forward, with an ignored start of opposite mode while busy.
        run(1'b0, 300, 0);
        // Inverse, with an ignored start during the first stage.
        run(1'b1, 50, 0);
        // Reset mid-transform, then a clean restart must follow the same schedule.
        run(1'($urandom), 0, int'($urandom_range(5, 900)));
        repeat (2) @(posedge clk);
        #1;
        run(1'b1, 0, 0);
        // Random modes and gaps, including back-to-back starts.
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
            run(1'($urandom), (r == 1) ? int'($urandom_range(10, 900)) : 0, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
